// File: rtl/mem_wb_fwd_pipe_pkg.sv
// Shared types and constants for the MEM/WB forwarding pipeline slice.
package mem_wb_fwd_pipe_pkg;
  localparam int unsigned DW_DEF = 32;
  localparam int unsigned RW_DEF = 5;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/mem_wb_fwd_pipe_if.sv
// Data-memory port: master drives the request, slave returns data and ready.
interface mem_wb_fwd_pipe_if
  import mem_wb_fwd_pipe_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
);
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_rd;
  logic          dmem_wr;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_ready;

  modport master (
    output dmem_addr, dmem_wdata, dmem_rd, dmem_wr,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_addr, dmem_wdata, dmem_rd, dmem_wr,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_wb_fwd_pipe_loaduse.sv
// Combinational load-use hazard comparator between the EX load and ID sources.
module mem_wb_fwd_pipe_loaduse_detect
  import mem_wb_fwd_pipe_pkg::*;
#(
  parameter int unsigned RW = RW_DEF
) (
  input  logic          ex_mem_read,
  input  logic          ex_reg_write,
  input  logic [RW-1:0] ex_dest,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_uses_rt,
  output logic          load_use
);
  always_comb begin
    load_use = ex_mem_read & ex_reg_write & (ex_dest != '0) &
               ((ex_dest == id_rs) | (id_uses_rt & (ex_dest == id_rt)));
  end
endmodule

// File: rtl/mem_wb_fwd_pipe.sv
// EX/MEM and MEM/WB registers, data-memory port and stall/bubble generation.
// Optional macro FWD_R0_SUPPRESS_EN: never present register 0 as a forwarding source.
module mem_wb_fwd_pipe
  import mem_wb_fwd_pipe_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_mem_read,
  input  logic                 ex_mem_write,
  input  logic                 ex_reg_write,
  input  logic                 ex_mem_to_reg,
  input  logic [RW-1:0]        ex_dest,
  input  logic [DW-1:0]        ex_res,
  input  logic [DW-1:0]        ex_bout,
  input  logic [RW-1:0]        id_rs,
  input  logic [RW-1:0]        id_rt,
  input  logic                 id_uses_rt,
  mem_wb_fwd_pipe_if.master    dmem,
  output logic                 reg_write_mem,
  output logic [RW-1:0]        dest_mem,
  output logic [DW-1:0]        fwd_mem,
  output logic                 reg_write_wb,
  output logic [RW-1:0]        dest_wb,
  output logic [DW-1:0]        fwd_wb,
  output logic                 stall,
  output logic                 bubble
);
  state_t        r_state;
  state_t        w_state_nxt;
  ctrl_t         r_mem_ctrl;
  logic [RW-1:0] r_mem_dest;
  logic [DW-1:0] r_mem_res;
  logic [DW-1:0] r_mem_bdata;
  logic          r_wb_rw;
  logic [RW-1:0] r_wb_dest;
  logic [DW-1:0] r_wb_data;
  logic          w_mem_stall;
  logic          w_load_use;

  mem_wb_fwd_pipe_loaduse_detect #(.RW(RW)) u_loaduse (
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .ex_dest      (ex_dest),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .load_use     (w_load_use)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_mem_stall = 1'b0;
    case (r_state)
      ST_RUN: begin
        if ((r_mem_ctrl.mem_read | r_mem_ctrl.mem_write) && !dmem.dmem_ready) begin
          w_state_nxt = ST_WAIT;
          w_mem_stall = 1'b1;
        end
      end
      ST_WAIT: begin
        if (dmem.dmem_ready) w_state_nxt = ST_RUN;
        else                 w_mem_stall = 1'b1;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // A waiting access freezes MEM; WB takes a bubble but keeps its last dest/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_ctrl  <= CTRL_NOP;
      r_mem_dest  <= '0;
      r_mem_res   <= '0;
      r_mem_bdata <= '0;
      r_wb_rw     <= 1'b0;
      r_wb_dest   <= '0;
      r_wb_data   <= '0;
    end else if (w_mem_stall) begin
      r_wb_rw <= 1'b0;
    end else begin
      r_mem_ctrl  <= '{mem_read:   ex_mem_read,
                       mem_write:  ex_mem_write,
                       reg_write:  ex_reg_write,
                       mem_to_reg: ex_mem_to_reg};
      r_mem_dest  <= ex_dest;
      r_mem_res   <= ex_res;
      r_mem_bdata <= ex_bout;
      r_wb_rw     <= r_mem_ctrl.reg_write;
      r_wb_dest   <= r_mem_dest;
      r_wb_data   <= r_mem_ctrl.mem_to_reg ? dmem.dmem_rdata : r_mem_res;
    end
  end

  always_comb begin
    dmem.dmem_addr  = r_mem_res;
    dmem.dmem_wdata = r_mem_bdata;
    dmem.dmem_rd    = r_mem_ctrl.mem_read;
    dmem.dmem_wr    = r_mem_ctrl.mem_write;
    dest_mem        = r_mem_dest;
    fwd_mem         = r_mem_res;
    dest_wb         = r_wb_dest;
    fwd_wb          = r_wb_data;
`ifdef FWD_R0_SUPPRESS_EN
    reg_write_mem   = r_mem_ctrl.reg_write & (r_mem_dest != '0);
    reg_write_wb    = r_wb_rw & (r_wb_dest != '0);
`else
    reg_write_mem   = r_mem_ctrl.reg_write;
    reg_write_wb    = r_wb_rw;
`endif
    // Gated by rst so the hazard path reads 0 while reset is held.
    stall           = !rst & (w_mem_stall | w_load_use);
    bubble          = !rst & w_load_use & !w_mem_stall;
  end
endmodule

// File: tb/tb_mem_wb_fwd_pipe.sv
// Self-checking bench: directed scenarios plus random traffic against an instruction-level model.
module tb_mem_wb_fwd_pipe;
  import mem_wb_fwd_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [4:0]  ex_dest, id_rs, id_rt;
  logic [31:0] ex_res, ex_bout;
  logic        id_uses_rt;
  logic        reg_write_mem, reg_write_wb, stall, bubble;
  logic [4:0]  dest_mem, dest_wb;
  logic [31:0] fwd_mem, fwd_wb;

  mem_wb_fwd_pipe_if #(.DW(32)) dmem ();

  mem_wb_fwd_pipe #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_dest(ex_dest), .ex_res(ex_res), .ex_bout(ex_bout),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .dmem(dmem),
    .reg_write_mem(reg_write_mem), .dest_mem(dest_mem), .fwd_mem(fwd_mem),
    .reg_write_wb(reg_write_wb), .dest_wb(dest_wb), .fwd_wb(fwd_wb),
    .stall(stall), .bubble(bubble)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rd, wr, rw, m2r;
    logic [4:0]  dest;
    logic [31:0] res, b;
  } inst_t;

  inst_t       m_mem;
  bit          m_wb_rw;
  logic [4:0]  m_wb_dest;
  logic [31:0] m_wb_data;

  function automatic bit fwd_en(bit rw, logic [4:0] d);
`ifdef FWD_R0_SUPPRESS_EN
    return rw && (d != 5'd0);
`else
    return rw;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mem     = '{rd: 0, wr: 0, rw: 0, m2r: 0, dest: '0, res: '0, b: '0};
    m_wb_rw   = 0;
    m_wb_dest = '0;
    m_wb_data = '0;
  endtask

  task automatic set_ex(input bit rd, input bit wr, input bit rw, input bit m2r,
                        input logic [4:0] d, input logic [31:0] res, input logic [31:0] b);
    ex_mem_read = rd; ex_mem_write = wr; ex_reg_write = rw; ex_mem_to_reg = m2r;
    ex_dest = d; ex_res = res; ex_bout = b;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input bit uses);
    id_rs = rs; id_rt = rt; id_uses_rt = uses;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rwm"},   reg_write_mem,   0);
    chk({tag, "_rwwb"},  reg_write_wb,    0);
    chk({tag, "_dm"},    dest_mem,        0);
    chk({tag, "_dwb"},   dest_wb,         0);
    chk({tag, "_fm"},    fwd_mem,         0);
    chk({tag, "_fwb"},   fwd_wb,          0);
    chk({tag, "_rd"},    dmem.dmem_rd,    0);
    chk({tag, "_wr"},    dmem.dmem_wr,    0);
    chk({tag, "_stall"}, stall,           0);
    chk({tag, "_bub"},   bubble,          0);
  endtask

  // One clock: compare against the model, then advance the model at the edge.
  task automatic cyc();
    bit ms, lu;
    #1;
    ms = (m_mem.rd || m_mem.wr) && !dmem.dmem_ready;
    lu = ex_mem_read && ex_reg_write && (ex_dest != 0) &&
         ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));
    chk("addr",   dmem.dmem_addr,  m_mem.res);
    chk("wdata",  dmem.dmem_wdata, m_mem.b);
    chk("rd",     dmem.dmem_rd,    m_mem.rd);
    chk("wr",     dmem.dmem_wr,    m_mem.wr);
    chk("rw_mem", reg_write_mem,   fwd_en(m_mem.rw, m_mem.dest));
    chk("dest_mem", dest_mem,      m_mem.dest);
    chk("fwd_mem",  fwd_mem,       m_mem.res);
    chk("rw_wb",  reg_write_wb,    fwd_en(m_wb_rw, m_wb_dest));
    chk("dest_wb", dest_wb,        m_wb_dest);
    chk("fwd_wb",  fwd_wb,         m_wb_data);
    chk("stall",   stall,          ms || lu);
    chk("bubble",  bubble,         lu && !ms);
    @(posedge clk);
    if (ms) begin
      m_wb_rw = 0;
    end else begin
      m_wb_rw   = m_mem.rw;
      m_wb_dest = m_mem.dest;
      m_wb_data = m_mem.m2r ? dmem.dmem_rdata : m_mem.res;
      m_mem = '{rd: ex_mem_read, wr: ex_mem_write, rw: ex_reg_write, m2r: ex_mem_to_reg,
                dest: ex_dest, res: ex_res, b: ex_bout};
    end
    #1;
  endtask

  initial begin
    set_ex(0, 0, 0, 0, 0, 0, 0);
    set_id(0, 0, 0);
    dmem.dmem_ready = 1'b1;
    dmem.dmem_rdata = '0;
    model_reset();
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // ALU op forwarded from MEM then WB
    set_ex(0, 0, 1, 0, 5'd8, 32'h1234, 32'h0);
    cyc();
    chk("alu_rw_mem", reg_write_mem, 1);
    chk("alu_dest_mem", dest_mem, 8);
    chk("alu_fwd_mem", fwd_mem, 32'h1234);
    set_ex(0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("alu_dest_wb", dest_wb, 8);
    chk("alu_fwd_wb", fwd_wb, 32'h1234);

    // Load-use on rs
    set_ex(1, 0, 1, 1, 5'd9, 32'h100, 32'h0);
    set_id(5'd9, 5'd0, 0);
    #1;
    chk("lu_stall", stall, 1);
    chk("lu_bubble", bubble, 1);
    cyc();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    set_id(0, 0, 0);
    dmem.dmem_rdata = 32'hCAFEF00D;
    cyc();
    chk("lu_dest_wb", dest_wb, 9);
    chk("lu_fwd_wb", fwd_wb, 32'hCAFEF00D);
    cyc();

    // Store with three wait states
    set_ex(0, 1, 0, 0, 0, 32'h200, 32'hDEADBEEF);
    cyc();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    dmem.dmem_ready = 1'b0;
    repeat (3) begin
      #1;
      chk("st_stall", stall, 1);
      chk("st_wr", dmem.dmem_wr, 1);
      chk("st_addr", dmem.dmem_addr, 32'h200);
      chk("st_wdata", dmem.dmem_wdata, 32'hDEADBEEF);
      cyc();
      chk("st_rw_wb", reg_write_wb, 0);
    end
    dmem.dmem_ready = 1'b1;
    #1;
    chk("st_release", stall, 0);
    cyc();
    chk("st_done_wr", dmem.dmem_wr, 0);

    // Load-use coincident with a memory wait
    set_ex(0, 1, 0, 0, 0, 32'h300, 32'h77);
    cyc();
    set_ex(1, 0, 1, 1, 5'd5, 32'h400, 32'h0);
    set_id(5'd5, 5'd1, 1);
    dmem.dmem_ready = 1'b0;
    repeat (2) begin
      #1;
      chk("co_bubble_wait", bubble, 0);
      chk("co_stall_wait", stall, 1);
      cyc();
    end
    dmem.dmem_ready = 1'b1;
    #1;
    chk("co_bubble_rel", bubble, 1);
    cyc();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    set_id(0, 0, 0);
    #1;
    chk("co_bubble_after", bubble, 0);
    cyc();
    cyc();

    // Write to register 0
    set_ex(0, 0, 1, 0, 5'd0, 32'h55, 32'h0);
    cyc();
`ifdef FWD_R0_SUPPRESS_EN
    chk("r0_rw_mem", reg_write_mem, 0);
`else
    chk("r0_rw_mem", reg_write_mem, 1);
`endif
    set_ex(0, 0, 0, 0, 0, 0, 0);
    cyc();
    cyc();

    // Reset asserted in the middle of a wait
    set_ex(1, 0, 1, 1, 5'd3, 32'h500, 32'h0);
    cyc();
    set_ex(0, 0, 0, 0, 0, 0, 0);
    dmem.dmem_ready = 1'b0;
    cyc();
    chk("rw_wait_rd", dmem.dmem_rd, 1);
    chk("rw_wait_state", dut.r_state, ST_WAIT);
    set_ex(1, 0, 1, 1, 5'd4, 32'h600, 32'h0);
    set_id(5'd4, 5'd0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    set_id(0, 0, 0);
    dmem.dmem_ready = 1'b1;
    #1;
    chk("midrst_state", dut.r_state, ST_RUN);
    cyc();

    // Random traffic
    repeat (400) begin
      logic rd, wr;
      rd = ($urandom_range(0, 3) == 0);
      wr = !rd && ($urandom_range(0, 4) == 0);
      set_ex(rd, wr, rd | ($urandom_range(0, 1) == 1), rd,
             5'($urandom_range(0, 3)), $urandom, $urandom);
      set_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
      dmem.dmem_ready = ($urandom_range(0, 3) != 0);
      dmem.dmem_rdata = $urandom;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_wb_fwd_pipe.md
Name: mem_wb_fwd_pipe

Overview:
- Producer side of the EX-stage forwarding interface.
- Holds the EX/MEM and MEM/WB pipeline registers and drives the data-memory port.
- Supplies the MEM- and WB-stage destination, write-enable and data values that the EX forwarding unit consumes.
- Generates the pipeline stall and bubble controls for load-use hazards and wait-stated data memory.

Parameters:
- DW, 32, datapath width (ALU result, store data, memory data).
- RW, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_mem_read  in  1  EX instruction is a load.
- ex_mem_write  in  1  EX instruction is a store.
- ex_reg_write  in  1  EX instruction writes the register file.
- ex_mem_to_reg  in  1  writeback data is taken from memory.
- ex_dest  in  RW  EX destination register (already Rd/Rt selected).
- ex_res  in  DW  EX ALU result / memory address.
- ex_bout  in  DW  forwarded B operand (store data).
- id_rs  in  RW  ID-stage source register rs.
- id_rt  in  RW  ID-stage source register rt.
- id_uses_rt  in  1  ID instruction reads rt.
- dmem_addr  out  DW  data memory address.
- dmem_wdata  out  DW  store data.
- dmem_rd  out  1  read request.
- dmem_wr  out  1  write request.
- dmem_rdata  in  DW  read data, valid when dmem_ready=1.
- dmem_ready  in  1  access completes this cycle.
- reg_write_mem  out  1  MEM-stage write enable (forwarding source).
- dest_mem  out  RW  MEM-stage destination register.
- fwd_mem  out  DW  MEM-stage ALU result.
- reg_write_wb  out  1  WB-stage write enable.
- dest_wb  out  RW  WB-stage destination register.
- fwd_wb  out  DW  WB writeback data.
- stall  out  1  hold PC, IF/ID and ID/EX.
- bubble  out  1  load ID/EX with a NOP this cycle.

Behaviour:
- Reset (async, immediate): all MEM/WB registers cleared.
  - reg_write_mem=0, reg_write_wb=0, dest_mem=0, dest_wb=0, fwd_mem=0, fwd_wb=0.
  - dmem_rd=0, dmem_wr=0, stall=0, bubble=0.
  - FSM returns to RUN. Any in-flight memory access is abandoned.
- MEM stage register holds: mem_read, mem_write, reg_write, mem_to_reg, dest, res, bdata.
  - Outputs are driven directly from it: dmem_addr=res, dmem_wdata=bdata, dmem_rd=mem_read, dmem_wr=mem_write, reg_write_mem, dest_mem, fwd_mem=res.
- WB stage register holds reg_write, dest and data.
  - Captured data = mem_to_reg ? dmem_rdata : res.
  - Latency: EX->MEM 1 cycle, MEM->WB 1 cycle when no wait states.
- FSM, state RUN:
  - If (dmem_rd|dmem_wr) and !dmem_ready: go to WAIT, assert mem_stall.
  - Otherwise both stages advance.
- FSM, state WAIT:
  - Assert mem_stall each cycle dmem_ready=0. MEM register holds, and dmem_rd/dmem_wr/addr/wdata stay stable.
  - On dmem_ready=1: advance and return to RUN.
- While mem_stall is asserted:
  - The WB register captures a bubble (reg_write=0, dest and data keep their old values).
  - The MEM register does not capture EX.
  - stall=1.
- Load-use hazard:
  - Condition: ex_mem_read & ex_reg_write & ex_dest!=0 & (ex_dest==id_rs | (id_uses_rt & ex_dest==id_rt)).
  - Response: stall=1, bubble=1 for exactly one cycle. The MEM register still captures the EX load.
- Simultaneous hazard and mem_stall: mem_stall wins.
  - stall=1, bubble=0, EX is not captured.
  - The hazard is re-evaluated after the stall releases.
- stall = mem_stall | load_use; bubble = load_use & !mem_stall. Both are combinational.
- Zero-wait memory (dmem_ready tied 1) never enters WAIT.

Optional Feature:
- Macro: FWD_R0_SUPPRESS_EN.
- When defined: reg_write_mem and reg_write_wb are forced 0 whenever the matching dest is 0, so register 0 is never a forwarding source.
- When undefined: the write enables pass through unmodified.

Decomposition:
- Shared package holds:
  - DW/RW defaults.
  - FSM state encoding: RUN=1'b0, WAIT=1'b1.
  - NOP control constant (all control bits 0).
- Natural sub-module: loaduse_detect, a purely combinational comparator producing load_use.

Test Plan:
- Reset asserted mid-WAIT with dmem_rd=1 -> all outputs 0 the same cycle; FSM reads RUN after release.
- ALU op dest=8, res=0x1234 -> next cycle reg_write_mem=1, dest_mem=8, fwd_mem=0x1234; following cycle dest_wb=8, fwd_wb=0x1234.
- Load into $9 in EX, ID rs=9 -> stall=1, bubble=1 for 1 cycle; two cycles later fwd_wb=dmem_rdata=0xCAFEF00D.
- Store with dmem_ready low for 3 cycles -> stall=1 for 3 cycles, dmem_wr/addr/wdata stable, reg_write_wb=0 during wait, then advance.
- Load-use hazard coincident with memory wait -> bubble=0 while waiting; bubble=1 for one cycle after dmem_ready=1.
- ALU op with dest=0, reg_write=1 -> reg_write_mem=0 with FWD_R0_SUPPRESS_EN, reg_write_mem=1 without.
